// File: rtl/iob2axi_wr.sv
// Native-slave write stream to AXI4-Full INCR write burst bridge.
// One burst per accepted run command; status reports completion and bresp error.
module iob2axi_wr #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = ADDR_W,
  parameter int AXI_DATA_W = DATA_W,
  parameter int AXI_ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    run,
  input  logic [AXI_ADDR_W-1:0]   addr,
  input  logic [7:0]              length,
  output logic                    ready,
  output logic                    error,

  input  logic                    s_valid,
  input  logic [ADDR_W-1:0]       s_addr,
  input  logic [DATA_W-1:0]       s_wdata,
  input  logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_ready,

  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              len_q, len_d;
  logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    beat_last;
  logic                    w_hs;

  // s_addr and bid carry nothing this bridge needs
  logic unused_ok;
  assign unused_ok = ^{s_addr, m_axi_bid};

  assign beat_last = (cnt_q == len_q);
  assign w_hs      = (state_q == WRITE) && s_valid && m_axi_wready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    addr_d        = addr_q;
    ready_d       = ready_q;
    error_d       = error_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    s_ready       = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && ready_q) begin
          addr_d  = addr;
          len_d   = length;
          cnt_d   = '0;
          error_d = 1'b0;
          ready_d = 1'b0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        m_axi_wvalid = s_valid;
        m_axi_wlast  = beat_last;
        s_ready      = s_valid && m_axi_wready;
        // counter parks on the final beat so a 256-beat burst never wraps
        if (w_hs) begin
          if (beat_last) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          error_d = |m_axi_bresp;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign ready         = ready_q;
  assign error         = error_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd2;
  assign m_axi_awprot  = 3'd2;
  assign m_axi_awqos   = 4'd0;

  assign m_axi_wdata   = s_wdata;
  assign m_axi_wstrb   = s_wstrb;

endmodule

// File: tb/tb_iob2axi_wr.sv
// Randomised bench for iob2axi_wr: a transaction-level model of the burst
// is checked against the DUT every cycle, plus directed literal expectations.
module tb_iob2axi_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] addr;
  logic [7:0]  length;
  logic        ready, error;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [0:0]  m_axi_awid, m_axi_bid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst, m_axi_bresp;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache, m_axi_awqos;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;

  iob2axi_wr dut (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .length(length),
    .ready(ready), .error(error),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a burst is "busy" from the accepted run until the
  // write response; inside it the address phase comes first, then len+1 beats.
  bit          m_busy = 1'b0;
  bit          m_aw   = 1'b0;
  bit          m_err  = 1'b0;
  int          m_beats = 0;
  int          m_len   = 0;
  logic [31:0] m_addr  = '0;
  int          aw_cnt = 0, b_cnt = 0;
  logic [31:0] last_awaddr;
  logic [7:0]  last_awlen;
  logic [31:0] obs_d[$];
  logic [3:0]  obs_s[$];
  logic        obs_l[$];

  always @(negedge clk) begin
    bit in_w, in_b;
    if (rst) begin
      m_busy = 1'b0; m_aw = 1'b0; m_err = 1'b0; m_beats = 0;
      chk("rst_ready", ready, 1);
      chk("rst_error", error, 0);
      chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_wvalid", m_axi_wvalid, 0);
      chk("rst_bready", m_axi_bready, 0);
      chk("rst_s_ready", s_ready, 0);
    end else begin
      in_w = m_busy && m_aw && (m_beats <= m_len);
      in_b = m_busy && m_aw && (m_beats > m_len);
      chk("ready", ready, !m_busy);
      chk("error", error, m_err);
      chk("awvalid", m_axi_awvalid, m_busy && !m_aw);
      chk("wvalid", m_axi_wvalid, in_w && s_valid);
      chk("s_ready", s_ready, in_w && s_valid && m_axi_wready);
      chk("bready", m_axi_bready, in_b);
      if (m_busy && !m_aw) begin
        chk("awaddr", m_axi_awaddr, m_addr);
        chk("awlen", m_axi_awlen, m_len);
      end
      if (in_w && s_valid) begin
        chk("wlast", m_axi_wlast, m_beats == m_len);
        chk("wdata", m_axi_wdata, s_wdata);
        chk("wstrb", m_axi_wstrb, s_wstrb);
      end
      if (!m_busy) begin
        if (run) begin
          m_busy = 1'b1; m_aw = 1'b0; m_beats = 0; m_err = 1'b0;
          m_addr = addr; m_len = int'(length);
        end
      end else if (!m_aw) begin
        if (m_axi_awready) begin
          m_aw = 1'b1; aw_cnt++;
          last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen;
        end
      end else if (in_w) begin
        if (s_valid && m_axi_wready) begin
          m_beats++;
          obs_d.push_back(m_axi_wdata);
          obs_s.push_back(m_axi_wstrb);
          obs_l.push_back(m_axi_wlast);
        end
      end else if (m_axi_bvalid) begin
        m_busy = 1'b0; m_err = |m_axi_bresp; b_cnt++;
      end
    end
  end

  task automatic drive_idle();
    run = 1'b0; s_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
  endtask

  // aw_dly<0: random awready; wr_mode 0 always / 1 alternating / 2 random;
  // sv_mode 0 continuous / 1 random gaps; abort_at>=0 resets at that beat index.
  task automatic burst(input logic [31:0] a, input int len, input int aw_dly, input int wr_mode,
                       input int sv_mode, input logic [1:0] resp, input bit pat, input bit poke,
                       input int abort_at);
    logic [31:0] drv_d[$];
    logic [3:0]  drv_s[$];
    int  idx, guard, n;
    bit  done, poked, hs, bhs;
    idx = 0; done = 1'b0; poked = 1'b0; guard = 0;
    obs_d.delete(); obs_s.delete(); obs_l.delete(); aw_cnt = 0; b_cnt = 0;
    for (int i = 0; i <= len; i++) begin
      drv_d.push_back(pat ? 32'hA0 + 32'(i) : $urandom);
      drv_s.push_back(pat ? 4'hF : 4'($urandom));
    end
    while (!ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("ready_before_run", ready, 1);
    run = 1'b1; addr = a; length = 8'(len);
    @(posedge clk); #1;
    run = 1'b0; addr = $urandom; length = 8'($urandom);
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      m_axi_awready = (aw_dly < 0) ? 1'($urandom) : (cyc >= aw_dly);
      m_axi_wready  = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? cyc[0] : ($urandom % 4 != 0);
      s_valid       = (idx <= len) && (sv_mode == 0 || $urandom % 3 != 0);
      s_wdata       = (idx <= len) ? drv_d[idx] : $urandom;
      s_wstrb       = (idx <= len) ? drv_s[idx] : 4'($urandom);
      s_addr        = $urandom;
      m_axi_bvalid  = (idx > len) && (wr_mode != 2 || 1'($urandom));
      m_axi_bresp   = resp;
      run = 1'b0;
      if (poke && !poked && idx == 2) begin
        run = 1'b1; addr = a ^ 32'h1000; poked = 1'b1;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_awvalid", m_axi_awvalid, 0);
        chk("abort_wvalid", m_axi_wvalid, 0);
        chk("abort_bready", m_axi_bready, 0);
        chk("abort_ready", ready, 1);
        chk("abort_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        return;
      end
      @(negedge clk);
      hs  = s_valid && s_ready;
      bhs = m_axi_bvalid && m_axi_bready;
      @(posedge clk); #1;
      if (hs) idx++;
      if (bhs) done = 1'b1;
    end
    drive_idle();
    chk("burst_done", done, 1);
    if (!done) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
    chk("aw_count", aw_cnt, 1);
    chk("b_count", b_cnt, 1);
    chk("beat_count", obs_d.size(), len + 1);
    n = (obs_d.size() < len + 1) ? obs_d.size() : len + 1;
    for (int i = 0; i < n; i++) begin
      chk("beat_data", obs_d[i], drv_d[i]);
      chk("beat_strb", obs_s[i], drv_s[i]);
      chk("beat_last", obs_l[i], i == len);
    end
    chk("ready_after", ready, 1);
    chk("error_after", error, resp != 2'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drive_idle(); addr = '0; length = '0;
    s_valid = 1'b1; s_wdata = '0; s_wstrb = '0; s_addr = '0; m_axi_bid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_error", error, 0);
    chk("reset_awaddr", m_axi_awaddr, 0);
    chk("reset_awlen", m_axi_awlen, 0);
    chk("awsize", m_axi_awsize, 3'd2);
    chk("awburst", m_axi_awburst, 2'd1);
    chk("awcache", m_axi_awcache, 4'd2);
    chk("awprot", m_axi_awprot, 3'd2);
    chk("awid", m_axi_awid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_ready_pending", s_ready, 0);
    chk("idle_awvalid", m_axi_awvalid, 0);
    s_valid = 1'b0;

    // single beat, everything immediate
    burst(32'h100, 0, 0, 0, 0, 2'd0, 1'b1, 1'b0, -1);
    chk("t1_awaddr", last_awaddr, 32'h100);
    chk("t1_awlen", last_awlen, 8'd0);
    chk("t1_wlast", (obs_l.size() == 1) ? obs_l[0] : 1'b0, 1);

    // 4 beats, awready after 3 cycles, wready alternating
    burst(32'h200, 3, 3, 1, 0, 2'd0, 1'b1, 1'b0, -1);
    chk("t2_last_data", (obs_d.size() > 3) ? obs_d[3] : 32'h0, 32'hA3);
    chk("t2_first_data", (obs_d.size() > 0) ? obs_d[0] : 32'h0, 32'hA0);

    // 8 beats with s_valid gaps
    burst(32'h300, 7, 0, 0, 1, 2'd0, 1'b1, 1'b0, -1);
    chk("t3_beats", obs_d.size(), 8);

    // SLVERR sets error, next clean burst clears it
    burst(32'h400, 2, 1, 2, 1, 2'd2, 1'b0, 1'b0, -1);
    chk("t4_error_set", error, 1);
    burst(32'h500, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, -1);
    chk("t4_error_clr", error, 0);

    // run poked mid-WRITE with another address; ends with DECERR
    burst(32'h2000, 5, 0, 0, 0, 2'd3, 1'b0, 1'b1, -1);
    chk("t5_awaddr", last_awaddr, 32'h2000);
    chk("t5_aw_once", aw_cnt, 1);

    // reset in the middle of a 16-beat burst, then a normal burst
    burst(32'h600, 15, 0, 0, 0, 2'd0, 1'b1, 1'b0, 6);
    chk("t6_awaddr_cleared", m_axi_awaddr, 0);
    chk("t6_ready", ready, 1);
    burst(32'h700, 15, 2, 2, 1, 2'd0, 1'b0, 1'b0, -1);

    // maximum length: 256 beats
    burst(32'hF000, 255, -1, 2, 1, 2'd0, 1'b0, 1'b0, -1);
    chk("max_beats", obs_d.size(), 256);

    for (int k = 0; k < 25; k++) begin
      int len_r;
      len_r = ($urandom % 5 == 0) ? int'($urandom % 256) : int'($urandom % 12);
      burst($urandom, len_r, ($urandom % 3 == 0) ? -1 : int'($urandom % 4),
            int'($urandom % 3), int'($urandom % 2), 2'($urandom), 1'b0,
            ($urandom % 4 == 0), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iob2axi_wr.md
Name: iob2axi_wr

Overview:
- Write-direction companion of the native-to-AXI read bridge.
- Converts a stream of native slave write accesses into one AXI4-Full master INCR write burst per `run` command.
- Sits between a native-bus producer (DMA or accelerator) and an AXI4 interconnect or memory controller.
- Control I/F supplies the burst address and length; a status register reports completion and the write-response error.

Parameters:
ADDR_W, 32, native address width
DATA_W, 32, native data width (power of 2, >=8)
AXI_ADDR_W, ADDR_W, AXI address width
AXI_DATA_W, DATA_W, AXI data width (must equal DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  start burst (sampled only while ready=1)
addr  in  AXI_ADDR_W  burst start address
length  in  AXI_LEN_W(8)  beats minus one
ready  out  1  idle / burst complete
error  out  1  last burst got non-OKAY bresp
s_valid  in  1  native write request
s_addr  in  ADDR_W  unused (address comes from control I/F)
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte enables
s_ready  out  1  beat accepted
m_axi_awid  out  AXI_ID_W(1)  constant 0
m_axi_awaddr  out  AXI_ADDR_W  latched addr
m_axi_awlen  out  8  latched length
m_axi_awsize  out  3  constant clog2(DATA_W/8)
m_axi_awburst  out  2  constant 1 (INCR)
m_axi_awlock  out  1  constant 0
m_axi_awcache  out  4  constant 2
m_axi_awprot  out  3  constant 2
m_axi_awqos  out  4  constant 0
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  AXI_DATA_W  = s_wdata
m_axi_wstrb  out  AXI_DATA_W/8  = s_wstrb
m_axi_wlast  out  1  final beat
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bid  in  AXI_ID_W  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset values:
  - ready=1, error=0, state=IDLE, counter=0, latched addr/length=0.
  - All valid/ready outputs are 0 combinationally in IDLE.
  - Reset mid-burst aborts immediately: no wlast or bready is completed and the block returns to IDLE.
- States: IDLE, ADDR, WRITE, RESP.
- IDLE:
  - ready=1.
  - run=1 latches addr and length, clears error and counter, then moves to ADDR.
  - ready is registered and drops the cycle after run.
- ADDR:
  - m_axi_awvalid=1, held until m_axi_awready; then moves to WRITE.
  - awaddr/awlen stay stable while awvalid=1.
- WRITE:
  - m_axi_wvalid=s_valid.
  - s_ready=s_valid&m_axi_wready, combinational, so the beat is accepted in the same cycle.
  - m_axi_wlast=(counter==length_reg).
  - Each handshake (wvalid&wready) increments counter.
  - A handshake with wlast moves to RESP.
  - s_valid gaps and wready stalls insert idle cycles without losing or duplicating beats.
  - No data is sent before the AW handshake completes.
- RESP:
  - m_axi_bready=1.
  - On m_axi_bvalid: error<=|m_axi_bresp, ready<=1, return to IDLE.
- ready and error are registered; error holds until the next accepted run.
- run while ready=0 is ignored. Parameters/addr changes while busy have no effect.
- Latency: ready returns 1 the cycle after the bvalid handshake.
- Counter width is 8 bits; it never wraps, since it stops at length_reg (max 255 → 256 beats).
- s_ready is 0 outside WRITE; s_valid outside WRITE is left pending.

Test Plan:
- Single beat: length=0, addr=0x100, awready=wready=bvalid immediate, bresp=0
  -> awaddr=0x100, awlen=0, one beat with wlast=1, ready back to 1, error=0.
- 4-beat burst with awready delayed 3 cycles and wready low every other cycle, data 0xA0..0xA3
  -> exactly 4 w handshakes in order, wlast only on 0xA3, s_ready pulses match handshakes.
- s_valid gaps mid-burst, length=7
  -> no extra beats, counter reaches 7, single bready handshake.
- bresp=2 (SLVERR) on completion
  -> error=1 after return to IDLE; next run with bresp=0 clears error to 0.
- run pulsed during WRITE with a different addr
  -> ignored; awaddr unchanged, only one AW handshake.
- rst asserted in the middle of a 16-beat burst
  -> awvalid/wvalid/bready=0 immediately, ready=1, error=0; a subsequent burst completes normally.
